// File: rtl/block_interleaver.sv
// block_interleaver: ROWS x COLS row/column bit interleaver/deinterleaver
// with ping-pong banks, so one block is written while the previous one
// drains.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   mode             0 = interleave, 1 = deinterleave (sampled with the first bit of each block)
//   din, din_valid   serial input bit and its qualifier
//   din_ready        write bank can accept a bit
//   dout, dout_valid serial output bit and its qualifier
//   dout_ready       downstream accepts dout
//   dout_last        high with the final bit of a block
module block_interleaver #(
  parameter int unsigned ROWS = 5,
  parameter int unsigned COLS = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic mode,
  input  logic din,
  input  logic din_valid,
  output logic din_ready,
  output logic dout,
  output logic dout_valid,
  input  logic dout_ready,
  output logic dout_last
);

  localparam int unsigned N  = ROWS * COLS;
  localparam int unsigned RW = $clog2(ROWS);
  localparam int unsigned CW = $clog2(COLS);
  localparam int unsigned AW = $clog2(N);

  logic [N-1:0]  mem [2];
  logic [1:0]    bmode;
  logic [1:0]    full;
  logic          wb;
  logic          rb;
  logic [RW-1:0] wr_r;
  logic [CW-1:0] wr_c;
  logic [RW-1:0] rd_r;
  logic [CW-1:0] rd_c;

  logic          wr_fire;
  logic          rd_fire;
  logic          wr_first;
  logic          wr_rfast;
  logic          rd_rfast;
  logic          wr_end;
  logic          rd_end;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;
  logic [RW-1:0] wr_r_nxt;
  logic [CW-1:0] wr_c_nxt;
  logic [RW-1:0] rd_r_nxt;
  logic [CW-1:0] rd_c_nxt;
  logic [1:0]    full_nxt;

  // Handshake, address decode and counter stepping.
  // Both traversal orders finish at (ROWS-1, COLS-1), so one end test serves both.
  always_comb begin
    wr_fire  = din_valid && !full[wb];
    rd_fire  = full[rb] && dout_ready;
    wr_first = (wr_r == '0) && (wr_c == '0);
    // The first bit of a block uses the live mode; later bits use the latched one.
    wr_rfast = wr_first ? mode : bmode[wb];
    rd_rfast = !bmode[rb];
    wr_end   = (wr_r == RW'(ROWS - 1)) && (wr_c == CW'(COLS - 1));
    rd_end   = (rd_r == RW'(ROWS - 1)) && (rd_c == CW'(COLS - 1));
    wr_addr  = AW'(wr_r) * AW'(COLS) + AW'(wr_c);
    rd_addr  = AW'(rd_r) * AW'(COLS) + AW'(rd_c);

    wr_r_nxt = wr_r;
    wr_c_nxt = wr_c;
    if (wr_end) begin
      wr_r_nxt = '0;
      wr_c_nxt = '0;
    end else if (wr_rfast) begin
      if (wr_r == RW'(ROWS - 1)) begin
        wr_r_nxt = '0;
        wr_c_nxt = wr_c + CW'(1);
      end else begin
        wr_r_nxt = wr_r + RW'(1);
      end
    end else begin
      if (wr_c == CW'(COLS - 1)) begin
        wr_c_nxt = '0;
        wr_r_nxt = wr_r + RW'(1);
      end else begin
        wr_c_nxt = wr_c + CW'(1);
      end
    end

    rd_r_nxt = rd_r;
    rd_c_nxt = rd_c;
    if (rd_end) begin
      rd_r_nxt = '0;
      rd_c_nxt = '0;
    end else if (rd_rfast) begin
      if (rd_r == RW'(ROWS - 1)) begin
        rd_r_nxt = '0;
        rd_c_nxt = rd_c + CW'(1);
      end else begin
        rd_r_nxt = rd_r + RW'(1);
      end
    end else begin
      if (rd_c == CW'(COLS - 1)) begin
        rd_c_nxt = '0;
        rd_r_nxt = rd_r + RW'(1);
      end else begin
        rd_c_nxt = rd_c + CW'(1);
      end
    end

    // Both firing implies wb != rb, so the two flag updates never collide.
    full_nxt = full;
    if (wr_fire && wr_end) full_nxt[wb] = 1'b1;
    if (rd_fire && rd_end) full_nxt[rb] = 1'b0;
  end

  // Bank storage, pointers and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      bmode  <= '0;
      full   <= '0;
      wb     <= 1'b0;
      rb     <= 1'b0;
      wr_r   <= '0;
      wr_c   <= '0;
      rd_r   <= '0;
      rd_c   <= '0;
    end else begin
      full <= full_nxt;
      if (wr_fire) begin
        mem[wb][wr_addr] <= din;
        if (wr_first) bmode[wb] <= mode;
        wr_r <= wr_r_nxt;
        wr_c <= wr_c_nxt;
        if (wr_end) wb <= !wb;
      end
      if (rd_fire) begin
        rd_r <= rd_r_nxt;
        rd_c <= rd_c_nxt;
        if (rd_end) rb <= !rb;
      end
    end
  end

  // Output decode straight from registers; none of it depends on din_valid or dout_ready.
  assign din_ready  = !full[wb];
  assign dout_valid = full[rb];
  assign dout       = full[rb] & mem[rb][rd_addr];
  assign dout_last  = full[rb] & rd_end;

endmodule

// File: tb/tb_block_interleaver.sv
// tb_block_interleaver: scoreboard bench for block_interleaver, using a 4x4
// instance for the directed cases and a default 5x8 instance for the
// interleave/deinterleave round trip.
module tb_block_interleaver;

  logic clk;
  logic rst_n;

  logic mode1, din1, dv1, rdy1, dout1, ov1, or1, last1;
  logic mode2, din2, dv2, rdy2, dout2, ov2, or2, last2;

  int n_tests;
  int n_fail;
  int stall1;
  int run1;
  int max_run1;
  logic [1:0] q1[$];
  logic [1:0] q2[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  block_interleaver #(.ROWS(4), .COLS(4)) u_d1 (
    .clk(clk), .rst_n(rst_n), .mode(mode1), .din(din1), .din_valid(dv1),
    .din_ready(rdy1), .dout(dout1), .dout_valid(ov1), .dout_ready(or1),
    .dout_last(last1)
  );

  block_interleaver u_d2 (
    .clk(clk), .rst_n(rst_n), .mode(mode2), .din(din2), .din_valid(dv2),
    .din_ready(rdy2), .dout(dout2), .dout_valid(ov2), .dout_ready(or2),
    .dout_last(last2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected interleave of a 5x8 block: output j comes from row j%5, column j/5.
  function automatic logic [39:0] il58(input logic [39:0] x);
    logic [39:0] y;
    for (int j = 0; j < 40; j++) y[j] = x[(j % 5) * 8 + j / 5];
    return y;
  endfunction

  task automatic exp1(input logic [15:0] v);
    for (int j = 0; j < 16; j++) q1.push_back({(j == 15), v[j]});
  endtask

  task automatic exp2(input logic [39:0] v);
    for (int j = 0; j < 40; j++) q2.push_back({(j == 39), v[j]});
  endtask

  task automatic mon1();
    logic [1:0] e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (ov1) run1++;
        else run1 = 0;
        if (run1 > max_run1) max_run1 = run1;
        if (ov1 && or1) begin
          if (q1.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL d1_unexpected_out: got dout=%b expected no output", dout1);
          end else begin
            e = q1.pop_front();
            check("d1_dout", 32'(dout1), 32'(e[0]));
            check("d1_last", 32'(last1), 32'(e[1]));
          end
        end
      end
    end
  endtask

  task automatic mon2();
    logic [1:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && ov2 && or2) begin
        if (q2.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL d2_unexpected_out: got dout=%b expected no output", dout2);
        end else begin
          e = q2.pop_front();
          check("d2_dout", 32'(dout2), 32'(e[0]));
          check("d2_last", 32'(last2), 32'(e[1]));
        end
      end
    end
  endtask

  // Present one bit and return at posedge+1 once it has been accepted.
  task automatic send1(input logic b, input logic m);
    logic ok;
    ok   = 1'b0;
    din1 = b;
    mode1 = m;
    dv1  = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (rdy1) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
      end else begin
        stall1++;
      end
    end
    dv1 = 1'b0;
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL d1_send_timeout: got din_ready=0 expected 1 within 200 cycles");
    end
  endtask

  task automatic send2(input logic b, input logic m);
    logic ok;
    ok   = 1'b0;
    din2 = b;
    mode2 = m;
    dv2  = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (rdy2) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
      end
    end
    dv2 = 1'b0;
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL d2_send_timeout: got din_ready=0 expected 1 within 200 cycles");
    end
  endtask

  task automatic blk1(input logic [15:0] v, input logic m);
    for (int i = 0; i < 16; i++) send1(v[i], m);
  endtask

  task automatic blk2(input logic [39:0] v, input logic m);
    for (int i = 0; i < 40; i++) send2(v[i], m);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 300; i++) begin
      if (q1.size() == 0 && q2.size() == 0) break;
      @(posedge clk);
    end
    repeat (3) @(posedge clk);
    #1;
    check("queues_drained", 32'(q1.size() + q2.size()), 32'd0);
  endtask

  initial begin
    logic [15:0] v;
    logic [39:0] x;
    logic [39:0] y;
    n_tests = 0;
    n_fail = 0;
    stall1 = 0;
    run1 = 0;
    max_run1 = 0;
    rst_n = 1'b0;
    mode1 = 1'b0; din1 = 1'b0; dv1 = 1'b0; or1 = 1'b1;
    mode2 = 1'b0; din2 = 1'b0; dv2 = 1'b0; or2 = 1'b1;
    fork
      mon1();
      mon2();
    join_none
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset in the middle of a block discards the partial data.
    for (int i = 0; i < 7; i++) send1(1'b1, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_din_ready", 32'(rdy1), 32'd1);
    check("rst_dout_valid", 32'(ov1), 32'd0);
    check("rst_dout", 32'(dout1), 32'd0);
    check("rst_dout_last", 32'(last1), 32'd0);
    @(posedge clk);
    #1;

    // Interleave 4x4: 000F -> 1111, first output right after the 16th input.
    v = 16'h000F;
    exp1(16'h1111);
    for (int i = 0; i < 16; i++) begin
      send1(v[i], 1'b0);
      if (i == 14) check("lat_valid_before_last", 32'(ov1), 32'd0);
      if (i == 15) begin
        check("lat_valid_after_last", 32'(ov1), 32'd1);
        check("lat_first_bit", 32'(dout1), 32'd1);
      end
    end
    wait_drain();

    // Deinterleave 4x4: 1111 -> 000F.
    exp1(16'h000F);
    blk1(16'h1111, 1'b1);
    wait_drain();

    // 5x8 round trip: interleave then deinterleave restores the input.
    x = 40'h1_90_10_21_01;
    y = il58(x);
    exp2(y);
    exp2(x);
    blk2(x, 1'b0);
    blk2(y, 1'b1);
    wait_drain();

    // Three back-to-back blocks with no bubbles.
    stall1 = 0;
    max_run1 = 0;
    exp1(16'h1111);
    exp1(16'h000F);
    exp1(16'hFFFF);
    blk1(16'h000F, 1'b0);
    blk1(16'h1111, 1'b1);
    blk1(16'hFFFF, 1'b0);
    wait_drain();
    check("stream_no_stall", 32'(stall1), 32'd0);
    check("stream_valid_run", 32'(max_run1), 32'd48);

    // Backpressure: both banks fill, then drain.
    or1 = 1'b0;
    exp1(16'h1111);
    exp1(16'h8888);
    blk1(16'h000F, 1'b0);
    blk1(16'hF000, 1'b0);
    din1 = 1'b0;
    dv1 = 1'b1;
    @(negedge clk);
    check("bp_ready_low", 32'(rdy1), 32'd0);
    check("bp_valid", 32'(ov1), 32'd1);
    check("bp_first_bit", 32'(dout1), 32'd1);
    check("bp_last_low", 32'(last1), 32'd0);
    repeat (3) @(negedge clk);
    check("bp_hold_dout", 32'(dout1), 32'd1);
    check("bp_hold_ready", 32'(rdy1), 32'd0);
    @(posedge clk);
    #1;
    dv1 = 1'b0;
    or1 = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i == 15) begin
        check("bp_ready_at_16th", 32'(rdy1), 32'd0);
        check("bp_last_at_16th", 32'(last1), 32'd1);
      end
    end
    @(negedge clk);
    check("bp_ready_back", 32'(rdy1), 32'd1);
    @(posedge clk);
    #1;
    wait_drain();

    // Mode change mid-block only takes effect on the next block.
    v = 16'h000F;
    exp1(16'h1111);
    exp1(16'h000F);
    for (int i = 0; i < 16; i++) send1(v[i], (i >= 5));
    blk1(16'h1111, 1'b1);
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
